// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: single-cycle results (port A) win over buffered long-latency
// results (port B), with a pending-register scoreboard for decode hazards and a starvation hold request.
module rf_writeback_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  output logic            hazard,
  output logic            wb_hold,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pending_q, pending_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              wb_hold_q, wb_hold_d;

  logic              fifo_empty, a_sel, lu_fire, head_sel, byp_sel, b_sel, b_write, push, pop;
  logic [4:0]        sel_rd;
  logic [XLEN-1:0]   sel_data;
  entry_t            head;

  // Write-port selection: A first, then FIFO head, then port-B bypass.
  always_comb begin
    fifo_empty = (count_q == {CNT_W{1'b0}});
    lu_ready   = (count_q != FULL_CNT);
    a_sel      = wb_valid && (wb_rd != 5'd0);
    lu_fire    = lu_valid && lu_ready;
    head_sel   = !a_sel && !fifo_empty;
    byp_sel    = !a_sel && fifo_empty && lu_fire;
    head       = fifo_q[rd_ptr_q];
    sel_rd     = 5'd0;
    sel_data   = {XLEN{1'b0}};
    b_sel      = 1'b0;
    if (a_sel) begin
      sel_rd   = wb_rd;
      sel_data = wb_data;
    end else if (head_sel) begin
      sel_rd   = head.rd;
      sel_data = head.data;
      b_sel    = 1'b1;
    end else if (byp_sel) begin
      sel_rd   = lu_rd;
      sel_data = lu_data;
      b_sel    = 1'b1;
    end else begin
      b_sel    = 1'b0;
    end
    // Gating with reset_n keeps the port quiet while reset is held, even with live inputs.
    rf_we    = reset_n && (sel_rd != 5'd0);
    rf_waddr = sel_rd;
    rf_wdata = sel_data;
    b_write  = rf_we && b_sel;
    hazard   = pending_q[rs1_addr] | pending_q[rs2_addr] | pending_q[rd_addr];
    wb_hold  = wb_hold_q;
  end

  // Next-state for FIFO, scoreboard and starvation tracking.
  always_comb begin
    push     = lu_fire && !byp_sel;
    pop      = head_sel;
    fifo_d   = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{rd: lu_rd, data: lu_data};
    end else begin
      fifo_d = fifo_q;
    end
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    pending_d = pending_q;
    if (b_write) begin
      pending_d[sel_rd] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    // Applied after the clear so a same-cycle issue to the same register wins.
    if (issue_valid) begin
      pending_d[issue_rd] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;

    if (pop || fifo_empty) begin
      starve_d = {STV_W{1'b0}};
    end else if (a_sel && (starve_q != STV_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end

    if (pop) begin
      wb_hold_d = 1'b0;
    end else if (starve_d == STV_MAX) begin
      wb_hold_d = 1'b1;
    end else begin
      wb_hold_d = wb_hold_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      pending_q <= 32'd0;
      starve_q  <= {STV_W{1'b0}};
      wb_hold_q <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      starve_q  <= starve_d;
      wb_hold_q <= wb_hold_d;
    end
  end

endmodule
